dev_stream_driver: RTL and testbench
====================================

Name: dev_stream_driver

Overview:
- Environment-side driver for a compiled reactive device: a Mealy machine with a 3-bit input, a 1-bit flag output and a 3-bit data output, advancing one step per clock.
- The device must be fed an input every cycle. This block supplies host symbols when available and a filler symbol otherwise.
- It captures the device reaction for every host symbol and returns those reactions to the host through a valid/ready response FIFO.
- It sits between a host stream and the device, so testbenches and SoC glue never have to meet the device's every-cycle timing.

Parameters:
- FILL, 3'h0, symbol driven on dev_in on cycles with no host symbol accepted.
- WARMUP, 4, filler cycles after reset before any host symbol is accepted; range 0..255.
- DEPTH, 4, response FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  host symbol valid
- in_ready  out  1  host symbol accepted this cycle when in_valid is also high
- in_data  in  3  host symbol
- dev_in  out  3  device input
- dev_out0  in  1  device flag output
- dev_out1  in  3  device data output
- resp_valid  out  1  FIFO non-empty
- resp_ready  in  1  host pops the FIFO head
- resp_data  out  4  FIFO head, {flag, data}
- sent_count  out  8  count of accepted host symbols, wraps modulo 256
- busy  out  1  high while in WARM state, or while FIFO non-empty

Behaviour:
- Reset: rst low clears all state asynchronously.
  - State goes to WARM (or RUN if WARMUP=0); warm counter is 0.
  - FIFO pointers are 0.
  - Reset values of outputs: resp_valid=0, in_ready=0, sent_count=0, busy=1 when WARMUP>0 and 0 otherwise, dev_in=FILL.
  - Reset released mid-stream: FIFO contents are discarded; no response is emitted for symbols in flight.
- State machine:
  - WARM: dev_in=FILL and in_ready=0. The counter increments each cycle; when it reaches WARMUP-1, the next state is RUN.
  - RUN: symbols are accepted as described below. The block stays in RUN until reset.
- Acceptance in RUN:
  - in_ready = (FIFO not full) OR (resp_valid AND resp_ready). A same-cycle pop frees space.
  - in_ready does not depend on in_valid.
  - Accept = in_valid AND in_ready.
- dev_in is combinational: in_data on an accepting cycle, otherwise FILL. There is zero latency from host symbol to device.
- Capture: on an accepting cycle, {dev_out0, dev_out1} is written at the FIFO tail on the same clock edge. The device outputs are combinational in dev_in and device state, so they belong to that symbol.
- Filler cycles are never captured. Their reactions are discarded, but they still advance the device.
- FIFO behaviour:
  - Ordering is first-in, first-out.
  - Pointers are log2(DEPTH)+1 bits. Full when the addresses are equal and the MSBs differ; empty when the pointers are equal.
  - Pointers wrap naturally.
  - resp_data is the head entry, a registered read with no bubble.
  - A response is visible on resp_valid the cycle after capture.
- Simultaneous push and pop:
  - When full: the pop and push both happen and occupancy is unchanged.
  - When empty: only the push happens; the popped entry does not exist and resp_valid=0, so no pop occurs.
- sent_count increments on each accept; 255 wraps to 0.
- busy = (state==WARM) OR resp_valid.

Test Plan:
- Reset and warm-up: WARMUP=4, DEPTH=4, in_valid=1 and in_data=3'h5 from reset release. in_ready is 0 for 4 cycles with dev_in=0; in cycle 5, in_ready=1 and dev_in=5. With an echo device stub (out0=1, out1=dev_in), resp_data=4'hD appears one cycle after accept.
- Backpressure and full: resp_ready=0, stream 3'h1 through 3'h6. Exactly 4 accepts, then in_ready=0 and sent_count=4. dev_in=FILL for the rest. Popping then yields 4'h9, 4'hA, 4'hB, 4'hC in order.
- Full with simultaneous pop: FIFO full and resp_ready=1, in_valid=1. in_ready=1, occupancy stays 4, head advances each cycle, and accepts continue one per cycle.
- Filler isolation: in_valid toggles 1,0,1 with data 2,x,3. Exactly two responses, 4'hA and 4'hB. Three device steps occur, with dev_in = 2, FILL, 3.
- Counter wrap: 257 accepts with resp_ready=1. sent_count reads 1 and no FIFO overflow occurs.
- Reset mid-operation: 3 entries queued, then rst pulled low for 1 cycle. resp_valid=0, sent_count=0, in_ready=0 immediately and asynchronously. Warm-up restarts and no stale responses appear.

Source files
------------

// File: rtl/dev_stream_driver.sv
// Host-to-device stream driver: feeds a reactive device one symbol per clock
// (host data or filler) and queues the device reaction to each host symbol.
module dev_stream_driver #(
    parameter logic [2:0]  FILL   = 3'h0,
    parameter int unsigned WARMUP = 4,
    parameter int unsigned DEPTH  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [2:0] in_data,
    output logic [2:0] dev_in,
    input  logic       dev_out0,
    input  logic [2:0] dev_out1,
    output logic       resp_valid,
    input  logic       resp_ready,
    output logic [3:0] resp_data,
    output logic [7:0] sent_count,
    output logic       busy
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned PW = AW + 1;
    localparam logic [7:0]  WARM_LAST = (WARMUP == 0) ? 8'd0 : 8'(WARMUP - 1);

    typedef enum logic {
        ST_WARM = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam state_e ST_RESET = (WARMUP == 0) ? ST_RUN : ST_WARM;

    typedef struct packed {
        logic       flag;
        logic [2:0] data;
    } resp_t;

    state_e          state_q, state_d;
    logic [7:0]      warm_cnt_q, warm_cnt_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [7:0]      sent_q, sent_d;
    resp_t           mem_q [DEPTH];
    resp_t           mem_d [DEPTH];

    logic            fifo_empty;
    logic            fifo_full;
    logic            pop;
    logic            accept;

    // Handshake and device feed; dev_in follows the host with zero latency
    always_comb begin
        fifo_empty = (wr_ptr_q == rd_ptr_q);
        fifo_full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                     (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]);
        resp_valid = !fifo_empty;
        pop        = resp_valid && resp_ready;
        in_ready   = (state_q == ST_RUN) && (!fifo_full || pop);
        accept     = in_valid && in_ready;
        dev_in     = accept ? in_data : FILL;
        resp_data  = mem_q[rd_ptr_q[AW-1:0]];
        sent_count = sent_q;
        busy       = (state_q == ST_WARM) || resp_valid;
    end

    // Warm-up sequencing
    always_comb begin
        state_d    = state_q;
        warm_cnt_d = warm_cnt_q;
        case (state_q)
            ST_WARM: begin
                warm_cnt_d = warm_cnt_q + 8'd1;
                if (warm_cnt_q == WARM_LAST) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RESET;
            end
        endcase
    end

    // Response FIFO and accept counter; reaction captured on the accepting edge
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q + PW'(accept);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        sent_d   = sent_q + 8'(accept);
        if (accept) begin
            mem_d[wr_ptr_q[AW-1:0]] = '{flag: dev_out0, data: dev_out1};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_RESET;
            warm_cnt_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            sent_q     <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            warm_cnt_q <= warm_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            sent_q     <= sent_d;
            mem_q      <= mem_d;
        end
    end

endmodule

// File: tb/tb_dev_stream_driver.sv
// Bench for dev_stream_driver: directed scenarios plus a random stream, checked
// against a queue-based model of the driver and a small device stub.
module tb_dev_stream_driver;

    localparam logic [2:0] FILL   = 3'h0;
    localparam int         WARMUP = 4;
    localparam int         DEPTH  = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [2:0] in_data = 3'h0;
    logic [2:0] dev_in;
    logic       dev_out0;
    logic [2:0] dev_out1;
    logic       resp_valid;
    logic       resp_ready = 1'b0;
    logic [3:0] resp_data;
    logic [7:0] sent_count;
    logic       busy;
    logic       dev_mode = 1'b0;

    always #5 clk = ~clk;

    dev_stream_driver #(.FILL(FILL), .WARMUP(WARMUP), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .dev_in(dev_in), .dev_out0(dev_out0), .dev_out1(dev_out1),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .sent_count(sent_count), .busy(busy)
    );

    // Device stub: echo (mode 0) or a stateful Mealy machine (mode 1)
    logic [2:0] dev_s;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) dev_s <= 3'h0;
        else      dev_s <= dev_s + dev_in + 3'd1;
    end
    assign dev_out0 = dev_mode ? (dev_s[0] ^ dev_in[2]) : 1'b1;
    assign dev_out1 = dev_mode ? (dev_s ^ dev_in) : dev_in;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int         m_warm;
    logic [3:0] m_q[$];
    int         m_sent;
    logic [2:0] m_dev;
    logic       e_ready, e_acc, e_pop, e_rv, e_busy;
    logic [2:0] e_dev_in;
    logic [3:0] e_head;

    function automatic logic [3:0] react(input logic [2:0] s, input logic [2:0] d);
        return dev_mode ? {s[0] ^ d[2], s ^ d} : {1'b1, d};
    endfunction

    task automatic model_reset();
        m_warm = WARMUP;
        m_q.delete();
        m_sent = 0;
        m_dev  = 3'h0;
    endtask

    task automatic model_eval();
        e_rv     = (m_q.size() != 0);
        e_pop    = e_rv && resp_ready;
        e_ready  = (m_warm == 0) && ((m_q.size() < DEPTH) || e_pop);
        e_acc    = in_valid && e_ready;
        e_dev_in = e_acc ? in_data : FILL;
        e_head   = e_rv ? m_q[0] : 4'h0;
        e_busy   = (m_warm != 0) || e_rv;
    endtask

    task automatic model_tick();
        if (e_pop) void'(m_q.pop_front());
        if (e_acc) begin
            m_q.push_back(react(m_dev, e_dev_in));
            m_sent = (m_sent + 1) % 256;
        end
        m_dev = m_dev + e_dev_in + 3'd1;
        if (m_warm > 0) m_warm--;
    endtask

    task automatic eval_at_neg();
        @(negedge clk);
        model_eval();
    endtask

    task automatic tick();
        @(posedge clk);
        model_tick();
        #1;
    endtask

    task automatic apply_reset();
        #2 rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic drain();
        in_valid   = 1'b0;
        resp_ready = 1'b1;
        for (int i = 0; i < DEPTH + 2; i++) begin
            eval_at_neg();
            tick();
        end
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        int first_acc;
        dev_mode = 1'b0; in_valid = 1'b1; in_data = 3'h5; resp_ready = 1'b0;
        rst = 1'b0;
        #3;
        n_tests++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid got %b want 0", resp_valid); end
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
        n_tests++; if (sent_count !== 8'd0) begin n_fail++; $display("FAIL reset_sent_count got %0d want 0", sent_count); end
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy got %b want 1", busy); end
        n_tests++; if (dev_in !== FILL) begin n_fail++; $display("FAIL reset_dev_in got %h want %h", dev_in, FILL); end
        model_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        first_acc = -1;
        for (int cyc = 1; cyc <= 7; cyc++) begin
            eval_at_neg();
            n_tests++; if (in_ready !== e_ready) begin n_fail++; $display("FAIL warm_in_ready cyc %0d got %b want %b", cyc, in_ready, e_ready); end
            n_tests++; if (dev_in !== e_dev_in) begin n_fail++; $display("FAIL warm_dev_in cyc %0d got %h want %h", cyc, dev_in, e_dev_in); end
            n_tests++; if (busy !== e_busy) begin n_fail++; $display("FAIL warm_busy cyc %0d got %b want %b", cyc, busy, e_busy); end
            if (cyc == 6) begin
                n_tests++; if (resp_data !== 4'hD || resp_valid !== 1'b1) begin n_fail++; $display("FAIL warm_first_resp got v=%b d=%h want v=1 d=d", resp_valid, resp_data); end
            end
            if (in_ready === 1'b1 && first_acc < 0) first_acc = cyc;
            tick();
        end
        n_tests++; if (first_acc != WARMUP + 1) begin n_fail++; $display("FAIL warm_first_accept_cycle got %0d want %0d", first_acc, WARMUP + 1); end
        drain();
    endtask

    task automatic test_backpressure();
        int accepts, start;
        logic [3:0] want;
        dev_mode = 1'b0; resp_ready = 1'b0; accepts = 0; start = m_sent;
        in_data = 3'h1; in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            eval_at_neg();
            n_tests++; if (dev_in !== e_dev_in) begin n_fail++; $display("FAIL bp_dev_in step %0d got %h want %h", i, dev_in, e_dev_in); end
            if (in_ready === 1'b1) accepts++;
            tick();
            if (e_acc && in_data != 3'h6) in_data = in_data + 3'd1;
        end
        eval_at_neg();
        n_tests++; if (accepts != DEPTH) begin n_fail++; $display("FAIL bp_accepts got %0d want %0d", accepts, DEPTH); end
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready_full got %b want 0", in_ready); end
        n_tests++; if (sent_count !== 8'((start + 4) % 256)) begin n_fail++; $display("FAIL bp_sent_count got %0d want %0d", sent_count, (start + 4) % 256); end
        n_tests++; if (dev_in !== FILL) begin n_fail++; $display("FAIL bp_dev_in_full got %h want %h", dev_in, FILL); end
        tick();
        in_valid = 1'b0; resp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            eval_at_neg();
            want = 4'h9 + 4'(i);
            n_tests++; if (resp_valid !== 1'b1 || resp_data !== want) begin n_fail++; $display("FAIL bp_pop %0d got v=%b d=%h want v=1 d=%h", i, resp_valid, resp_data, want); end
            tick();
        end
        eval_at_neg();
        n_tests++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty got %b want 0", resp_valid); end
        tick();
        resp_ready = 1'b0;
    endtask

    task automatic test_full_pop();
        int pops;
        dev_mode = 1'b0; resp_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            in_data = 3'($urandom);
            eval_at_neg();
            tick();
        end
        resp_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_data = 3'($urandom);
            eval_at_neg();
            n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL fullpop_in_ready step %0d got %b want 1", i, in_ready); end
            n_tests++; if (resp_valid !== 1'b1 || resp_data !== e_head) begin n_fail++; $display("FAIL fullpop_head step %0d got %h want %h", i, resp_data, e_head); end
            n_tests++; if (dev_in !== e_dev_in) begin n_fail++; $display("FAIL fullpop_dev_in step %0d got %h want %h", i, dev_in, e_dev_in); end
            tick();
        end
        in_valid = 1'b0; pops = 0;
        for (int i = 0; i < 8; i++) begin
            eval_at_neg();
            if (resp_valid === 1'b1) pops++;
            tick();
        end
        n_tests++; if (pops != DEPTH) begin n_fail++; $display("FAIL fullpop_occupancy got %0d want %0d", pops, DEPTH); end
        resp_ready = 1'b0;
    endtask

    task automatic test_filler();
        logic [2:0] vd [3];
        logic [2:0] wd [3];
        logic [3:0] wr [2];
        int nresp;
        vd = '{3'h2, 3'h5, 3'h3};
        wd = '{3'h2, FILL, 3'h3};
        wr = '{4'hA, 4'hB};
        dev_mode = 1'b0; resp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = (i != 1);
            in_data  = vd[i];
            eval_at_neg();
            n_tests++; if (dev_in !== wd[i]) begin n_fail++; $display("FAIL filler_dev_in step %0d got %h want %h", i, dev_in, wd[i]); end
            tick();
        end
        in_valid = 1'b0; resp_ready = 1'b1; nresp = 0;
        for (int i = 0; i < 5; i++) begin
            eval_at_neg();
            if (resp_valid === 1'b1) begin
                if (nresp < 2) begin
                    n_tests++; if (resp_data !== wr[nresp]) begin n_fail++; $display("FAIL filler_resp %0d got %h want %h", nresp, resp_data, wr[nresp]); end
                end
                nresp++;
            end
            tick();
        end
        n_tests++; if (nresp != 2) begin n_fail++; $display("FAIL filler_count got %0d want 2", nresp); end
        resp_ready = 1'b0;
    endtask

    task automatic test_wrap();
        int accepts, stalls, cyc;
        dev_mode = 1'b0;
        apply_reset();
        in_valid = 1'b1; resp_ready = 1'b1; accepts = 0; stalls = 0; cyc = 0;
        while (accepts < 257 && cyc < 400) begin
            in_data = 3'($urandom);
            eval_at_neg();
            if (e_rv) begin
                n_tests++; if (resp_data !== e_head) begin n_fail++; $display("FAIL wrap_resp cyc %0d got %h want %h", cyc, resp_data, e_head); end
            end
            if (in_ready === 1'b1) accepts++;
            else stalls++;
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        eval_at_neg();
        n_tests++; if (accepts != 257) begin n_fail++; $display("FAIL wrap_accepts got %0d want 257 (budget)", accepts); end
        n_tests++; if (stalls != WARMUP) begin n_fail++; $display("FAIL wrap_stalls got %0d want %0d", stalls, WARMUP); end
        n_tests++; if (sent_count !== 8'd1) begin n_fail++; $display("FAIL wrap_sent_count got %0d want 1", sent_count); end
        tick();
        drain();
    endtask

    task automatic test_random();
        dev_mode = 1'b1;
        for (int i = 0; i < 400; i++) begin
            in_valid   = ($urandom % 4) != 0;
            in_data    = 3'($urandom);
            resp_ready = ($urandom % 2) != 0;
            eval_at_neg();
            n_tests++; if (in_ready !== e_ready) begin n_fail++; $display("FAIL rnd_in_ready %0d got %b want %b", i, in_ready, e_ready); end
            n_tests++; if (dev_in !== e_dev_in) begin n_fail++; $display("FAIL rnd_dev_in %0d got %h want %h", i, dev_in, e_dev_in); end
            n_tests++; if (resp_valid !== e_rv) begin n_fail++; $display("FAIL rnd_resp_valid %0d got %b want %b", i, resp_valid, e_rv); end
            n_tests++; if (busy !== e_busy) begin n_fail++; $display("FAIL rnd_busy %0d got %b want %b", i, busy, e_busy); end
            n_tests++; if (sent_count !== 8'(m_sent)) begin n_fail++; $display("FAIL rnd_sent_count %0d got %0d want %0d", i, sent_count, m_sent); end
            if (e_rv) begin
                n_tests++; if (resp_data !== e_head) begin n_fail++; $display("FAIL rnd_resp_data %0d got %h want %h", i, resp_data, e_head); end
            end
            tick();
        end
        drain();
    endtask

    task automatic test_reset_mid();
        dev_mode = 1'b0; resp_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 3'($urandom);
            eval_at_neg();
            tick();
        end
        in_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        n_tests++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_resp_valid got %b want 0", resp_valid); end
        n_tests++; if (sent_count !== 8'd0) begin n_fail++; $display("FAIL mid_sent_count got %0d want 0", sent_count); end
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_in_ready got %b want 0", in_ready); end
        model_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        in_valid = 1'b1;
        for (int cyc = 1; cyc <= 7; cyc++) begin
            in_data = 3'($urandom);
            eval_at_neg();
            n_tests++; if (in_ready !== e_ready) begin n_fail++; $display("FAIL mid_warm_in_ready cyc %0d got %b want %b", cyc, in_ready, e_ready); end
            n_tests++; if (resp_valid !== e_rv) begin n_fail++; $display("FAIL mid_stale_resp cyc %0d got %b want %b", cyc, resp_valid, e_rv); end
            if (e_rv) begin
                n_tests++; if (resp_data !== e_head) begin n_fail++; $display("FAIL mid_resp_data cyc %0d got %h want %h", cyc, resp_data, e_head); end
            end
            tick();
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_backpressure();
        test_full_pop();
        test_filler();
        test_wrap();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout reached without finishing");
        $fatal(1, "timeout");
    end

endmodule
